sim_frame_ctrl: RTL and testbench

Simulation-support block that sits directly upstream of the waveform-dump module in the MiST test harness. It converts the raw `VGA_VS` and download `led` signals into a clean frame counter, a one-cycle frame-boundary pulse and a registered dump-window enable, so the dump logic only has to compare a flag instead of matching on raw sync edges. With the frame-limit feature compiled in, it also tells the test bench when to finish the simulation.

---
 rtl/sim_frame_ctrl.sv | 126 ++++++++++++
 tb/tb_sim_frame_ctrl.sv | 351 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sim_frame_ctrl.sv
// Frame counter, frame-boundary pulse and dump-window enable derived from raw VGA_VS and download led.
// Optional macro FRAME_LIMIT_EN adds a DONE state that raises sim_finish at MAXFRAME frames.
//
// state   | meaning
// WAIT_DL | download in progress (or just out of reset); count held at 0
// RUN     | counting VS falling edges
// DONE    | frame limit reached; count frozen, sim_finish held (FRAME_LIMIT_EN only)
module sim_frame_ctrl #(
    parameter int unsigned DUMP_START = 0,
    parameter int unsigned DUMP_LEN   = 0,
    parameter int unsigned MAXFRAME   = 1000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        VGA_VS,
    input  logic        led,
    output logic [31:0] frame_cnt,
    output logic        vs_fall,
    output logic        dump_on,
    output logic        dl_done,
    output logic        sim_finish
);

`ifdef FRAME_LIMIT_EN
    typedef enum logic [1:0] {WAIT_DL, RUN, DONE} state_t;
`else
    typedef enum logic [1:0] {WAIT_DL, RUN} state_t;
`endif

    localparam logic [32:0] WIN_START = 33'(DUMP_START);
    localparam logic [32:0] WIN_END   = 33'(DUMP_START) + 33'(DUMP_LEN);

    state_t      state;
    logic        vs_m, vs_s, vs_d;
    logic        led_m, led_s, led_d;
    logic        vs_edge, led_fall;
    logic [31:0] cnt_inc;
    logic [33:0] lo_diff, hi_diff;
    logic        in_window;

    assign vs_edge  = vs_d & ~vs_s;
    assign led_fall = led_d & ~led_s;
    assign cnt_inc  = frame_cnt + 32'd1;

    // Window bounds compared through a borrow bit so the end never wraps and no
    // comparison collapses to a constant when the bounds are zero.
    assign lo_diff   = {2'b00, frame_cnt} - {1'b0, WIN_START};
    assign hi_diff   = {2'b00, frame_cnt} - {1'b0, WIN_END};
    assign in_window = ~lo_diff[33] & ((DUMP_LEN == 0) | hi_diff[33]);

`ifndef FRAME_LIMIT_EN
    assign sim_finish = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= WAIT_DL;
            vs_m      <= 1'b0;
            vs_s      <= 1'b0;
            vs_d      <= 1'b0;
            led_m     <= 1'b0;
            led_s     <= 1'b0;
            led_d     <= 1'b0;
            frame_cnt <= 32'd0;
            vs_fall   <= 1'b0;
            dump_on   <= 1'b0;
            dl_done   <= 1'b0;
`ifdef FRAME_LIMIT_EN
            sim_finish <= 1'b0;
`endif
        end else begin
            vs_m  <= VGA_VS;
            vs_s  <= vs_m;
            vs_d  <= vs_s;
            led_m <= led;
            led_s <= led_m;
            led_d <= led_s;

            vs_fall <= 1'b0;
            dl_done <= 1'b0;
            dump_on <= (state == RUN) && in_window;

            case (state)
                WAIT_DL: begin
                    frame_cnt <= 32'd0;
                    if (!led_s) begin
                        state   <= RUN;
                        dl_done <= led_fall;
                    end
                end
                RUN: begin
                    // Reload takes priority over a coincident VS edge.
                    if (led_s) begin
                        state     <= WAIT_DL;
                        frame_cnt <= 32'd0;
                    end
`ifdef FRAME_LIMIT_EN
                    else if (frame_cnt == 32'(MAXFRAME)) begin
                        state      <= DONE;
                        sim_finish <= 1'b1;
                    end
`endif
                    else if (vs_edge) begin
                        frame_cnt <= cnt_inc;
                        vs_fall   <= 1'b1;
`ifdef FRAME_LIMIT_EN
                        if (cnt_inc == 32'(MAXFRAME)) begin
                            state      <= DONE;
                            sim_finish <= 1'b1;
                        end
`endif
                    end
                end
`ifdef FRAME_LIMIT_EN
                DONE: begin
                    sim_finish <= 1'b1;
                end
`endif
                default: begin
                    state <= WAIT_DL;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sim_frame_ctrl.sv
// Self-checking bench for sim_frame_ctrl; a scoreboard holds the expected count and
// arrival cycle of every vs_fall pulse. Expectations follow FRAME_LIMIT_EN when defined.
module tb_sim_frame_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        VGA_VS = 1'b0;
    logic        led = 1'b0;
    logic [31:0] frame_cnt;
    logic        vs_fall;
    logic        dump_on;
    logic        dl_done;
    logic        sim_finish;

    sim_frame_ctrl #(
        .DUMP_START(4),
        .DUMP_LEN  (3),
        .MAXFRAME  (10)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .VGA_VS    (VGA_VS),
        .led       (led),
        .frame_cnt (frame_cnt),
        .vs_fall   (vs_fall),
        .dump_on   (dump_on),
        .dl_done   (dl_done),
        .sim_finish(sim_finish)
    );

    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [31:0] cnt;
        int unsigned cyc;
    } exp_t;

    exp_t        sb[$];
    int          n_checks = 0;
    int          n_fail = 0;
    int          dl_cnt = 0;
    int          vsf_cnt = 0;
    int unsigned dl_cyc = 0;
    logic [31:0] model_cnt = 0;

`ifdef FRAME_LIMIT_EN
    localparam int   LIM_COUNTED = 10;
    localparam logic LIM_FINISH  = 1'b1;
`else
    localparam int   LIM_COUNTED = 12;
    localparam logic LIM_FINISH  = 1'b0;
`endif

    function automatic logic win(input int k);
        return (k >= 4) && (k < 7);
    endfunction

    task automatic do_reset(input logic led_val);
        @(negedge clk);
        rst = 1'b1;
        led = led_val;
        VGA_VS = 1'b0;
        sb.delete();
        model_cnt = 0;
        repeat (2) @(negedge clk);
        dl_cnt = 0;
        vsf_cnt = 0;
        rst = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    task automatic vs_rise();
        @(negedge clk);
        VGA_VS = 1'b1;
        repeat (4) @(negedge clk);
    endtask

    // Called right after a negedge; drives the falling edge and records the expectation.
    task automatic vs_drop(input bit counted);
        VGA_VS = 1'b0;
        if (counted) begin
            model_cnt = model_cnt + 1;
            sb.push_back('{cnt: model_cnt, cyc: cyc + 3});
        end
        repeat (6) @(negedge clk);
    endtask

    task automatic vs_edge(input bit counted);
        vs_rise();
        vs_drop(counted);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        led = 1'b0;
        VGA_VS = 1'b0;
        repeat (2) @(negedge clk);
        n_checks++;
        if ({frame_cnt, vs_fall, dump_on, dl_done, sim_finish} !== 36'd0) begin
            n_fail++;
            $display("FAIL reset_outputs got cnt=%0d vf=%b dump=%b dl=%b fin=%b, want all 0",
                     frame_cnt, vs_fall, dump_on, dl_done, sim_finish);
        end
        rst = 1'b0;
        repeat (5) @(negedge clk);
        n_checks++;
        if (dl_done !== 1'b0 || frame_cnt !== 32'd0) begin
            n_fail++;
            $display("FAIL post_reset got cnt=%0d dl=%b, want 0 0", frame_cnt, dl_done);
        end
    endtask

    task automatic test_led_low();
        do_reset(1'b0);
        for (int i = 0; i < 5; i++) vs_edge(1'b1);
        n_checks++;
        if (frame_cnt !== 32'd5) begin
            n_fail++;
            $display("FAIL led_low_count got %0d want 5", frame_cnt);
        end
        n_checks++;
        if (vsf_cnt != 5) begin
            n_fail++;
            $display("FAIL led_low_pulses got %0d want 5", vsf_cnt);
        end
        n_checks++;
        if (dl_cnt != 0) begin
            n_fail++;
            $display("FAIL led_low_dl_done got %0d pulses want 0", dl_cnt);
        end
        n_checks++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL led_low_missing got %0d pending want 0", sb.size());
        end
    endtask

    task automatic test_download();
        int unsigned exp_cyc;
        do_reset(1'b1);
        repeat (5) @(negedge clk);
        for (int i = 0; i < 3; i++) vs_edge(1'b0);
        repeat (60) @(negedge clk);
        n_checks++;
        if (frame_cnt !== 32'd0 || vsf_cnt != 0) begin
            n_fail++;
            $display("FAIL download_hold got cnt=%0d pulses=%0d want 0 0", frame_cnt, vsf_cnt);
        end
        led = 1'b0;
        exp_cyc = cyc + 3;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (dl_cnt != 0) break;
        end
        n_checks++;
        if (dl_cnt != 1 || dl_cyc != exp_cyc) begin
            n_fail++;
            $display("FAIL dl_done_pulse got n=%0d cyc=%0d want n=1 cyc=%0d", dl_cnt, dl_cyc, exp_cyc);
        end
        vs_edge(1'b1);
        vs_edge(1'b1);
        n_checks++;
        if (frame_cnt !== 32'd2 || dl_cnt != 1) begin
            n_fail++;
            $display("FAIL download_run got cnt=%0d dl=%0d want 2 1", frame_cnt, dl_cnt);
        end
        n_checks++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL download_missing got %0d pending want 0", sb.size());
        end
    endtask

    task automatic test_dump_window();
        bit got;
        do_reset(1'b0);
        n_checks++;
        if (dump_on !== 1'b0) begin
            n_fail++;
            $display("FAIL dump_idle got %b want 0", dump_on);
        end
        for (int k = 1; k <= 7; k++) begin
            vs_rise();
            VGA_VS = 1'b0;
            model_cnt = model_cnt + 1;
            sb.push_back('{cnt: model_cnt, cyc: cyc + 3});
            got = 1'b0;
            for (int i = 0; i < 6; i++) begin
                @(negedge clk);
                if (vs_fall) begin
                    got = 1'b1;
                    break;
                end
            end
            n_checks++;
            if (!got || dump_on !== win(k - 1)) begin
                n_fail++;
                $display("FAIL dump_lag k=%0d got seen=%b dump=%b want seen=1 dump=%b",
                         k, got, dump_on, win(k - 1));
            end
            @(negedge clk);
            n_checks++;
            if (dump_on !== win(k) || frame_cnt !== 32'(k)) begin
                n_fail++;
                $display("FAIL dump_window k=%0d got dump=%b cnt=%0d want dump=%b cnt=%0d",
                         k, dump_on, frame_cnt, win(k), k);
            end
            repeat (3) @(negedge clk);
        end
    endtask

    task automatic test_reload();
        vs_rise();
        led = 1'b1;
        VGA_VS = 1'b0;
        repeat (8) @(negedge clk);
        n_checks++;
        if (frame_cnt !== 32'd0 || dump_on !== 1'b0 || vsf_cnt != 7) begin
            n_fail++;
            $display("FAIL reload got cnt=%0d dump=%b pulses=%0d want 0 0 7", frame_cnt, dump_on, vsf_cnt);
        end
        led = 1'b0;
        repeat (6) @(negedge clk);
        n_checks++;
        if (dl_cnt != 1 || sb.size() != 0) begin
            n_fail++;
            $display("FAIL reload_end got dl=%0d pending=%0d want 1 0", dl_cnt, sb.size());
        end
    endtask

    task automatic test_wrap_async();
        bit got;
        do_reset(1'b0);
        force dut.frame_cnt = 32'hFFFF_FFFE;
        @(negedge clk);
        release dut.frame_cnt;
        model_cnt = 32'hFFFF_FFFE;
        repeat (2) @(negedge clk);
        for (int i = 0; i < 3; i++) vs_edge(1'b1);
        n_checks++;
        if (frame_cnt !== 32'd1 || sb.size() != 0) begin
            n_fail++;
            $display("FAIL wrap got cnt=%0d pending=%0d want 1 0", frame_cnt, sb.size());
        end
        vs_rise();
        VGA_VS = 1'b0;
        got = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk);
            #1;
            if (vs_fall) begin
                got = 1'b1;
                break;
            end
        end
        n_checks++;
        if (!got || frame_cnt !== 32'd2) begin
            n_fail++;
            $display("FAIL pre_async got seen=%b cnt=%0d want 1 2", got, frame_cnt);
        end
        rst = 1'b1;
        #2;
        n_checks++;
        if ({frame_cnt, vs_fall, dump_on, dl_done, sim_finish} !== 36'd0) begin
            n_fail++;
            $display("FAIL async_reset got cnt=%0d vf=%b dump=%b dl=%b fin=%b, want all 0",
                     frame_cnt, vs_fall, dump_on, dl_done, sim_finish);
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_frame_limit();
        do_reset(1'b0);
        for (int i = 1; i <= 12; i++) vs_edge(i <= LIM_COUNTED);
        n_checks++;
        if (frame_cnt !== 32'(LIM_COUNTED) || sim_finish !== LIM_FINISH) begin
            n_fail++;
            $display("FAIL frame_limit got cnt=%0d fin=%b want %0d %b",
                     frame_cnt, sim_finish, LIM_COUNTED, LIM_FINISH);
        end
`ifdef FRAME_LIMIT_EN
        led = 1'b1;
        repeat (10) @(negedge clk);
        led = 1'b0;
        repeat (10) @(negedge clk);
        n_checks++;
        if (frame_cnt !== 32'd10 || sim_finish !== 1'b1 || dl_cnt != 0) begin
            n_fail++;
            $display("FAIL limit_led_ignored got cnt=%0d fin=%b dl=%0d want 10 1 0",
                     frame_cnt, sim_finish, dl_cnt);
        end
`endif
        n_checks++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL limit_missing got %0d pending want 0", sb.size());
        end
    endtask

    initial begin
        fork
            forever begin
                exp_t e;
                @(negedge clk);
                if (!rst) begin
                    if (dl_done) begin
                        dl_cnt++;
                        dl_cyc = cyc;
                    end
                    if (vs_fall) begin
                        vsf_cnt++;
                        n_checks++;
                        if (sb.size() == 0) begin
                            n_fail++;
                            $display("FAIL unexpected_vs_fall got cnt=%0d at cyc=%0d want no pulse",
                                     frame_cnt, cyc);
                        end else begin
                            e = sb.pop_front();
                            if (frame_cnt !== e.cnt || cyc != e.cyc) begin
                                n_fail++;
                                $display("FAIL vs_fall_sb got cnt=%0d cyc=%0d want cnt=%0d cyc=%0d",
                                         frame_cnt, cyc, e.cnt, e.cyc);
                            end
                        end
                    end
                end
            end
            begin
                #500000;
                $display("FAIL timeout got no completion want finish before 500000");
                $fatal(1, "timeout");
            end
        join_none

        test_reset();
        test_led_low();
        test_download();
        test_dump_window();
        test_reload();
        test_wrap_async();
        test_frame_limit();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
